// File: rtl/dmux8way16_router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared types and constants for the dmux8way16_router write-side router.
//   WIDTH        : data width of the input stream and every output channel
//   NUM_CH       : number of output channels (fixed at 8, 3-bit select)
//   ch_sel_t     : destination channel index
//   word_t       : one data word
//   slot_state_t : occupancy of a one-entry channel holding register
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int WIDTH  = 16;
    localparam int NUM_CH = 8;

    typedef logic [2:0]       ch_sel_t;
    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : router_pkg

// File: rtl/dmux8way16_router_slot.sv
// -----------------------------------------------------------------------------
// router_slot
// One output channel of the router: a single-entry holding register with a
// valid/ready handshake towards its consumer.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset (empties slot, clears data)
//   wr_en_i   : a word addressed to this channel is transferred in this cycle
//   wr_data_i : word being written
//   rd_ready_i: consumer takes the held word this cycle
//   valid_o   : slot holds a word (FULL)
//   data_o    : held word; keeps its stale value after being read
// -----------------------------------------------------------------------------
module router_slot
    import router_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  wr_en_i,
    input  word_t wr_data_i,
    input  logic  rd_ready_i,
    output logic  valid_o,
    output word_t data_o
);

    slot_state_t state_q;
    word_t       data_q;

    // A write is only ever issued when the slot is empty or being drained in
    // the same cycle, so a write always leaves the slot FULL with new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else if (wr_en_i) begin
            state_q <= SLOT_FULL;
            data_q  <= wr_data_i;
        end else if (state_q == SLOT_FULL && rd_ready_i) begin
            // Drain only: data is left as-is, only the valid flag drops.
            state_q <= SLOT_EMPTY;
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

endmodule : router_slot

// File: rtl/dmux8way16_router.sv
// -----------------------------------------------------------------------------
// dmux8way16_router
// Routes one tagged 16-bit word stream to eight independent output channels,
// each backed by a one-entry holding register so a stalled consumer only
// blocks words addressed to it.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   in_valid     : producer offers in_data/in_sel
//   in_ready     : router accepts the offered word (combinational on
//                  in_sel/out_ready, independent of in_valid)
//   in_data      : word to route
//   in_sel       : destination channel, 0=a ... 7=h
//   a..h         : channel data outputs
//   out_valid    : per-channel valid
//   out_ready    : per-channel consumer ready
//   accept_count : (only with DMUX8WAY16_ROUTER_COUNT_EN) saturating count of
//                  accepted input words
// Build option: define DMUX8WAY16_ROUTER_COUNT_EN to add accept_count.
// -----------------------------------------------------------------------------
module dmux8way16_router
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [2:0]        in_sel,
    output logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  c,
    output logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  e,
    output logic [WIDTH-1:0]  f,
    output logic [WIDTH-1:0]  g,
    output logic [WIDTH-1:0]  h,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready
`ifdef DMUX8WAY16_ROUTER_COUNT_EN
    ,
    output logic [15:0]       accept_count
`endif
);

    logic              in_xfer;
    logic [NUM_CH-1:0] wr_en;
    word_t             ch_data [NUM_CH];

    // Target slot can take a word if empty or if it is drained this cycle.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
    assign in_xfer  = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
            assign wr_en[gi] = in_xfer && (in_sel == ch_sel_t'(gi));

            router_slot u_slot (
                .clk        (clk),
                .rst_n      (rst_n),
                .wr_en_i    (wr_en[gi]),
                .wr_data_i  (in_data),
                .rd_ready_i (out_ready[gi]),
                .valid_o    (out_valid[gi]),
                .data_o     (ch_data[gi])
            );
        end
    endgenerate

    assign a = ch_data[0];
    assign b = ch_data[1];
    assign c = ch_data[2];
    assign d = ch_data[3];
    assign e = ch_data[4];
    assign f = ch_data[5];
    assign g = ch_data[6];
    assign h = ch_data[7];

`ifdef DMUX8WAY16_ROUTER_COUNT_EN
    logic [15:0] count_q;

    // Saturates at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (in_xfer && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign accept_count = count_q;
`endif

endmodule : dmux8way16_router

// File: tb/tb_dmux8way16_router.sv
module tb_dmux8way16_router;
    import router_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [2:0]  in_sel = '0;
    logic [7:0]  out_ready = '0;
    logic        in_ready;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [7:0]  out_valid;
`ifdef DMUX8WAY16_ROUTER_COUNT_EN
    logic [15:0] accept_count;
`endif

    dmux8way16_router dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .h         (h),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DMUX8WAY16_ROUTER_COUNT_EN
        ,
        .accept_count (accept_count)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] obs [8];
    assign obs[0] = a;
    assign obs[1] = b;
    assign obs[2] = c;
    assign obs[3] = d;
    assign obs[4] = e;
    assign obs[5] = f;
    assign obs[6] = g;
    assign obs[7] = h;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: each channel is a queue of words not yet consumed
    // (capacity one), plus the last word ever written for the stale value.
    logic [15:0] mq [8][$];
    logic [15:0] last_word [8];
    int          acc_total = 0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
        n_cmp++;
        assert (o === x) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
        end
    endtask

    function automatic bit model_ready();
        return (mq[in_sel].size() == 0) || out_ready[in_sel];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            mq[k].delete();
            last_word[k] = '0;
        end
        acc_total = 0;
    endtask

    task automatic check_all(input string tag);
        chk($sformatf("%s.in_ready", tag), 32'(in_ready), 32'(model_ready()));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s.valid%0d", tag, k), 32'(out_valid[k]), 32'(mq[k].size() > 0));
            chk($sformatf("%s.data%0d", tag, k), 32'(obs[k]),
                32'((mq[k].size() > 0) ? mq[k][0] : last_word[k]));
        end
`ifdef DMUX8WAY16_ROUTER_COUNT_EN
        chk($sformatf("%s.count", tag), 32'(accept_count),
            32'((acc_total > 65535) ? 65535 : acc_total));
`endif
    endtask

    // Apply model transition for the inputs that will be present at the edge.
    task automatic model_edge();
        bit acc;
        acc = in_valid && model_ready();
        for (int k = 0; k < 8; k++)
            if (out_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
        if (acc) begin
            mq[in_sel].push_back(in_data);
            last_word[in_sel] = in_data;
            acc_total++;
        end
    endtask

    // Called at posedge+1 with inputs set: check, update model, advance.
    task automatic cycle(input string tag);
        #3;
        check_all(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();

        // ---- 1. Reset ----
        @(posedge clk); #1;
        check_all("rst_init");
        rst_n = 1'b1;
        in_valid = 1'b1; in_sel = 3'd2; in_data = 16'h2222;
        cycle("fill2");
        in_sel = 3'd5; in_data = 16'h5555;
        cycle("fill5");
        in_valid = 1'b0;
        cycle("full25");
        chk("full25.out_valid", 32'(out_valid), 32'h24);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        chk("rst_async.out_valid", 32'(out_valid), 32'h00);
        @(posedge clk); #1;
        check_all("rst_hold");
        rst_n = 1'b1;
        cycle("rst_rel");

        // ---- 2. Single route ----
        in_valid = 1'b1; in_sel = 3'd3; in_data = 16'hBEEF; out_ready = 8'h00;
        cycle("route3");
        in_valid = 1'b0;
        chk("route3.out_valid", 32'(out_valid), 32'h08);
        chk("route3.d", 32'(d), 32'hBEEF);
        cycle("route3_hold");

        // ---- 3. Backpressure ----
        in_valid = 1'b1; in_sel = 3'd6; in_data = 16'h1111;
        cycle("bp_fill");
        in_data = 16'h2222;
        cycle("bp_stall0");
        chk("bp_stall0.in_ready", 32'(in_ready), 32'h0);
        cycle("bp_stall1");
        chk("bp_stall1.g", 32'(g), 32'h1111);
        out_ready = 8'h40;
        cycle("bp_rw");
        in_valid = 1'b0; out_ready = 8'h00;
        chk("bp_rw.g", 32'(g), 32'h2222);
        chk("bp_rw.valid6", 32'(out_valid[6]), 32'h1);
        cycle("bp_after");
        out_ready = 8'hFF;
        cycle("drain");

        // ---- 4. Streaming ----
        out_ready = 8'h01; in_valid = 1'b1; in_sel = 3'd0;
        for (int i = 1; i <= 20; i++) begin
            in_data = 16'(i);
            #3;
            chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'h1);
            #0;
            #(-0);
            cycle($sformatf("stream%0d", i - 0)) ;
            chk($sformatf("stream%0d.a", i), 32'(a), 32'(i));
        end
        in_valid = 1'b0;
        cycle("stream_end");

        // ---- 5. Isolation ----
        out_ready = 8'h00; in_valid = 1'b1; in_sel = 3'd1; in_data = 16'hA001;
        cycle("iso_fill1");
        out_ready = 8'h10;
        for (int i = 0; i < 20; i++) begin
            in_sel = (i % 2 == 0) ? 3'd1 : 3'd4;
            in_data = 16'($urandom);
            cycle($sformatf("iso%0d", i));
        end
        in_valid = 1'b0; out_ready = 8'hFF;
        cycle("iso_drain");

        // ---- Random traffic ----
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom);
            in_sel = 3'($urandom);
            in_data = 16'($urandom);
            out_ready = 8'($urandom);
            cycle($sformatf("rnd%0d", i));
        end
        in_valid = 1'b0; out_ready = 8'hFF;
        cycle("rnd_drain");

`ifdef DMUX8WAY16_ROUTER_COUNT_EN
        // ---- 6. Counter saturation ----
        in_valid = 1'b1; out_ready = 8'hFF;
        for (int i = 0; i < 70000; i++) begin
            in_sel = 3'($urandom);
            in_data = 16'($urandom);
            model_edge();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cycle("sat");
        chk("sat.count", 32'(accept_count), 32'hFFFF);
        out_ready = 8'h00; in_valid = 1'b1; in_sel = 3'd7; in_data = 16'h7777;
        cycle("sat_fill");
        cycle("sat_stall");
        chk("sat_stall.count", 32'(accept_count), 32'hFFFF);
        in_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_dmux8way16_router
